// File: rtl/ex_ctrl_pkg.sv
// Shared constants and types for the EX-stage hazard controller and its mult/div sequencer.
package ex_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) &&
           ((funct == FN_MULT) || (funct == FN_MULTU) ||
            (funct == FN_DIV)  || (funct == FN_DIVU));
  endfunction

endpackage

// File: rtl/mdu_seq.sv
// Sequencer for the shared iterative mult/div unit: start/abort pulses and pipeline stall.
module mdu_seq
  import ex_ctrl_pkg::*;
#(
  parameter int LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic md_op,
  input  logic flush,
  output logic start,
  output logic abort,
  output logic busy,
  output logic stall
);

  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(LATENCY - 1);

  mdu_state_t state, state_nxt;
  logic [MDU_CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    abort     = 1'b0;
    busy      = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (md_op) begin
          if (flush) begin
            abort   = 1'b1;
            cnt_nxt = '0;
          end else begin
            start     = 1'b1;
            stall     = 1'b1;
            cnt_nxt   = CNT_LOAD;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (flush) begin
          abort     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          if (cnt == '0) state_nxt = DONE;
          else           cnt_nxt   = cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset silences the pulses so a mid-operation reset never reads as an abort.
    if (rst) begin
      start = 1'b0;
      abort = 1'b0;
      stall = 1'b0;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage forwarding, load-use, branch-flush and mult/div stall control.
// Macro EX_HAZARD_MDU_EN builds the mult/div sequencer; without it mdu_* outputs are 0.
module ex_hazard_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 32
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [5:0] opE,
  input  logic [5:0] funcE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       branchM,
  input  logic       ZeroM,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       mdu_start,
  output logic       mdu_abort,
  output logic       mdu_busy
);

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic rw_m, input logic [4:0] wr_m,
                                         input logic rw_w, input logic [4:0] wr_w);
    if (rw_m && (wr_m != 5'd0) && (wr_m == src))      return FWD_MEM;
    else if (rw_w && (wr_w != 5'd0) && (wr_w == src)) return FWD_WB;
    else                                              return FWD_RF;
  endfunction

  logic branch_taken;
  logic load_use;
  logic lu_stall;
  logic seq_stall;

  assign forwardAE = fwd_sel(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
  assign forwardBE = fwd_sel(rtE, regWriteM, writeRegM, regWriteW, writeRegW);

  assign branch_taken = branchM & ZeroM;
  assign load_use     = (opE == OP_LW) && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));

`ifdef EX_HAZARD_MDU_EN
  mdu_seq #(
    .LATENCY (MDU_LATENCY)
  ) u_mdu_seq (
    .clk   (CLK),
    .rst   (reset),
    .md_op (is_md_op(opE, funcE)),
    .flush (branch_taken),
    .start (mdu_start),
    .abort (mdu_abort),
    .busy  (mdu_busy),
    .stall (seq_stall)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{funcE, CLK, reset, MDU_CNT_W'(MDU_LATENCY)};
  assign mdu_start  = 1'b0;
  assign mdu_abort  = 1'b0;
  assign mdu_busy   = 1'b0;
  assign seq_stall  = 1'b0;
`endif

  // A taken branch outranks both stall sources; a busy sequencer masks load-use.
  assign lu_stall = load_use & ~mdu_busy & ~branch_taken;

  assign stallF = seq_stall | lu_stall;
  assign stallD = seq_stall | lu_stall;
  assign stallE = seq_stall;
  assign flushD = branch_taken;
  assign flushE = branch_taken | lu_stall;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_ex_hazard_ctrl;

  localparam int LAT = 4;

`ifdef EX_HAZARD_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, wM, wW;
    logic [5:0] op, fn;
    logic       rwM, rwW, br, z;
  } stim_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic sF, sD, sE, fD, fE, st, ab, bz;
  } exp_t;

  logic       CLK = 1'b0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegM, writeRegW;
  logic [5:0] opE, funcE;
  logic       regWriteM, regWriteW, branchM, ZeroM;
  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, flushD, flushE;
  logic       mdu_start, mdu_abort, mdu_busy;

  ex_hazard_ctrl #(.MDU_LATENCY(LAT)) dut (
    .CLK(CLK), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .opE(opE), .funcE(funcE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteM(regWriteM), .regWriteW(regWriteW), .branchM(branchM), .ZeroM(ZeroM),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .flushD(flushD), .flushE(flushE), .mdu_start(mdu_start),
    .mdu_abort(mdu_abort), .mdu_busy(mdu_busy)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Reference model state: cycles of BUSY still to run, and whether this cycle is DONE.
  int   m_busy_left = 0;
  bit   m_done = 1'b0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input stim_t s);
    if (s.rwM && s.wM != 0 && s.wM == src) return 2'd2;
    if (s.rwW && s.wW != 0 && s.wW == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s.rst = 1'b0; s.rsD = 0; s.rtD = 0; s.rsE = 0; s.rtE = 0; s.wM = 0; s.wW = 0;
    s.op = 6'd0; s.fn = 6'b100000; s.rwM = 0; s.rwW = 0; s.br = 0; s.z = 0;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit taken, md, lu, busy, idet, mst, lus;
    @(posedge CLK);
    #1;
    reset = s.rst; rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
    writeRegM = s.wM; writeRegW = s.wW; opE = s.op; funcE = s.fn;
    regWriteM = s.rwM; regWriteW = s.rwW; branchM = s.br; ZeroM = s.z;

    taken = s.br && s.z;
    md    = MDU_ON && s.op == 6'd0 && s.fn >= 6'd24 && s.fn <= 6'd27;
    lu    = s.op == 6'd35 && s.rtE != 0 && (s.rtE == s.rsD || s.rtE == s.rtD);
    busy  = m_busy_left > 0;
    idet  = !busy && !m_done && md;
    mst   = (idet || busy) && !taken && !s.rst;
    lus   = lu && !busy && !taken;

    e.fa = ref_fwd(s.rsE, s);
    e.fb = ref_fwd(s.rtE, s);
    e.sF = mst || lus;
    e.sD = mst || lus;
    e.sE = mst;
    e.fD = taken;
    e.fE = taken || lus;
    e.st = idet && !taken && !s.rst;
    e.ab = (idet || busy) && taken && !s.rst;
    e.bz = busy;
    exp_q.push_back(e);

    if (s.rst || e.ab) begin
      m_busy_left = 0; m_done = 1'b0;
    end else if (e.st) begin
      m_busy_left = LAT; m_done = 1'b0;
    end else if (busy) begin
      m_busy_left = m_busy_left - 1;
      m_done = (m_busy_left == 0);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("forwardAE", forwardAE, e.fa);
      chk("forwardBE", forwardBE, e.fb);
      chk("stallF", {1'b0, stallF}, {1'b0, e.sF});
      chk("stallD", {1'b0, stallD}, {1'b0, e.sD});
      chk("stallE", {1'b0, stallE}, {1'b0, e.sE});
      chk("flushD", {1'b0, flushD}, {1'b0, e.fD});
      chk("flushE", {1'b0, flushE}, {1'b0, e.fE});
      chk("mdu_start", {1'b0, mdu_start}, {1'b0, e.st});
      chk("mdu_abort", {1'b0, mdu_abort}, {1'b0, e.ab});
      chk("mdu_busy", {1'b0, mdu_busy}, {1'b0, e.bz});
    end
  end

  initial begin : driver
    stim_t s;
    int r;
    s = quiet();
    reset = 1'b1; rsD = 0; rtD = 0; rsE = 0; rtE = 0; writeRegM = 0; writeRegW = 0;
    opE = 0; funcE = 6'b100000; regWriteM = 0; regWriteW = 0; branchM = 0; ZeroM = 0;

    s.rst = 1'b1; step(s); step(s);
    s = quiet(); step(s);

    // forwarding: MEM beats WB; register 0 never forwards
    s = quiet(); s.rwM = 1; s.wM = 5; s.rwW = 1; s.wW = 5; s.rsE = 5; step(s);
    s.wM = 0; s.rsE = 0; step(s);
    s = quiet(); s.rwW = 1; s.wW = 7; s.rtE = 7; step(s);

    // load-use
    s = quiet(); s.op = 6'b100011; s.rtE = 8; s.rsD = 8; step(s);
    s = quiet(); step(s);
    s = quiet(); s.op = 6'b100011; s.rtE = 0; s.rsD = 0; step(s);

    // branch
    s = quiet(); s.br = 1; s.z = 1; step(s);
    s.z = 0; step(s);

    // mult held in EX through BUSY and DONE
    s = quiet(); s.fn = 6'b011000;
    for (int i = 0; i < LAT + 2; i++) step(s);
    s = quiet(); step(s);

    // abort by taken branch during BUSY
    s = quiet(); s.fn = 6'b011000; step(s); step(s);
    s.br = 1; s.z = 1; step(s);
    s = quiet(); step(s); step(s);

    // reset while BUSY
    s = quiet(); s.fn = 6'b011001; step(s); step(s);
    s = quiet(); s.rst = 1; step(s);
    s = quiet(); step(s);

    // div, then back-to-back divu
    s = quiet(); s.fn = 6'b011010;
    for (int i = 0; i < LAT + 2; i++) step(s);
    s.fn = 6'b011011;
    for (int i = 0; i < LAT + 2; i++) step(s);
    s = quiet(); step(s);

    for (int n = 0; n < 2000; n++) begin
      s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
      s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
      s.wM  = 5'($urandom_range(0, 3)); s.wW  = 5'($urandom_range(0, 3));
      s.rwM = 1'($urandom_range(0, 1)); s.rwW = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      case (r)
        0, 1:    s.op = 6'b100011;
        5:       s.op = 6'b101011;
        6:       s.op = 6'b000100;
        7:       s.op = 6'b000101;
        default: s.op = 6'b000000;
      endcase
      s.fn  = ($urandom_range(0, 1) == 0) ? 6'(24 + $urandom_range(0, 3)) : 6'b100000;
      s.br  = ($urandom_range(0, 3) == 0);
      s.z   = 1'($urandom_range(0, 1));
      s.rst = ($urandom_range(0, 63) == 0);
      step(s);
    end
    stim_done = 1'b1;
  end

  initial begin : finisher
    for (int i = 0; i < 20000 && !stim_done; i++) @(posedge CLK);
    if (!stim_done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete");
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
